// File: rtl/fpga_cfg_loader.sv
// -----------------------------------------------------------------------------
// fpga_cfg_loader
//
// Purpose:
//   Byte-stream configuration controller for the FPGA fabric tile. It accepts
//   a framed bitstream (MAGIC, LEN lo, LEN hi, payload, XOR checksum) over an
//   8-bit valid/ready port. Each payload byte is serialised MSB-first into the
//   fabric configuration shift chain. If the checksum matches, the chain is
//   committed with a one-cycle latch pulse and the fabric is enabled. Otherwise
//   the fabric stays disabled and the error flag is raised.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   in_data      frame byte
//   in_valid     in_data valid
//   in_ready     loader accepts a byte this cycle (depends on state only)
//   chain_dout   serial bit into the config chain
//   chain_shift  chain shift enable (chain samples chain_dout on this edge)
//   chain_latch  one-cycle commit pulse to the chain shadow registers
//   fabric_en    fabric datapath enable
//   busy         frame in progress (LEN_LO through CHECK)
//   error        last frame failed
//   state_o      current state encoding, for debug
// -----------------------------------------------------------------------------
module fpga_cfg_loader #(
  parameter logic [7:0]  MAGIC     = 8'hA5,
  parameter logic [15:0] MAX_BYTES = 16'd512
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       chain_dout,
  output logic       chain_shift,
  output logic       chain_latch,
  output logic       fabric_en,
  output logic       busy,
  output logic       error,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    LOAD   = 3'd3,
    SHIFT  = 3'd4,
    CHECK  = 3'd5,
    DONE   = 3'd6,
    ERROR  = 3'd7
  } state_e;

  state_e      state_q;
  logic [7:0]  len_lo_q;
  logic [15:0] remain_q;
  logic [7:0]  shreg_q;
  logic [7:0]  chksum_q;
  logic [2:0]  bit_cnt_q;
  logic        latch_q;
  logic        fabric_en_q;
  logic        error_q;

  logic        accept;
  logic [15:0] len_d;

  // The only state that stalls the input is SHIFT; everything else accepts.
  assign in_ready    = (state_q != SHIFT);
  assign accept      = in_valid && in_ready;
  assign len_d       = {in_data, len_lo_q};

  assign chain_shift = (state_q == SHIFT);
  assign chain_dout  = chain_shift & shreg_q[7];
  assign chain_latch = latch_q;
  assign fabric_en   = fabric_en_q;
  assign error       = error_q;
  assign busy        = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                       (state_q == LOAD)   || (state_q == SHIFT)  ||
                       (state_q == CHECK);
  assign state_o     = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_lo_q    <= 8'd0;
      remain_q    <= 16'd0;
      shreg_q     <= 8'd0;
      chksum_q    <= 8'd0;
      bit_cnt_q   <= 3'd0;
      latch_q     <= 1'b0;
      fabric_en_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      // The commit pulse is only ever one cycle wide.
      latch_q <= 1'b0;

      case (state_q)
        IDLE, DONE, ERROR: begin
          // Non-MAGIC bytes are consumed and dropped without side effects.
          if (accept && (in_data == MAGIC)) begin
            state_q     <= LEN_LO;
            chksum_q    <= 8'd0;
            fabric_en_q <= 1'b0;
            error_q     <= 1'b0;
          end
        end

        LEN_LO: begin
          if (accept) begin
            len_lo_q <= in_data;
            state_q  <= LEN_HI;
          end
        end

        LEN_HI: begin
          if (accept) begin
            remain_q <= len_d;
            if (len_d > MAX_BYTES) begin
              state_q <= ERROR;
              error_q <= 1'b1;
            end else if (len_d == 16'd0) begin
              state_q <= CHECK;
            end else begin
              state_q <= LOAD;
            end
          end
        end

        LOAD: begin
          if (accept) begin
            shreg_q   <= in_data;
            chksum_q  <= chksum_q ^ in_data;
            bit_cnt_q <= 3'd0;
            state_q   <= SHIFT;
          end
        end

        SHIFT: begin
          // Exactly 8 cycles per byte; the remaining count drops after the
          // last bit, so a value of 1 here means this was the final byte.
          shreg_q   <= {shreg_q[6:0], 1'b0};
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            remain_q <= remain_q - 16'd1;
            state_q  <= (remain_q == 16'd1) ? CHECK : LOAD;
          end
        end

        CHECK: begin
          if (accept) begin
            if (in_data == chksum_q) begin
              latch_q     <= 1'b1;
              fabric_en_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              error_q <= 1'b1;
              state_q <= ERROR;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_fpga_cfg_loader
//
// Purpose:
//   Self-checking bench for fpga_cfg_loader. Frames are built as byte lists
//   (directed and random), and the expected chain bit stream and outcome are
//   derived from the frame contents by a byte-level reference model.
// -----------------------------------------------------------------------------
module tb_fpga_cfg_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       chain_dout;
  logic       chain_shift;
  logic       chain_latch;
  logic       fabric_en;
  logic       busy;
  logic       error;
  logic [2:0] state_o;

  fpga_cfg_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .chain_dout  (chain_dout),
    .chain_shift (chain_shift),
    .chain_latch (chain_latch),
    .fabric_en   (fabric_en),
    .busy        (busy),
    .error       (error),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observed chain activity, sampled on the falling edge
  bit shiftBits[$];
  int latchCount = 0;
  int notReadyCount = 0;

  always @(negedge clk) begin
    if (chain_shift) shiftBits.push_back(chain_dout);
    if (chain_latch) latchCount++;
    if (!in_ready) notReadyCount++;
  end

  // Frame under test and the model's expectations for it
  logic [7:0] frameQ[$];
  bit         expBits[$];
  bit         expOk;
  bit         expOver;
  int         expLen;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: parse the frame by its format rules
  task automatic modelFromFrame();
    int i;
    logic [7:0] x;
    i = 0;
    expBits.delete();
    while (i < frameQ.size() && frameQ[i] != 8'hA5) i++;
    expLen  = int'(frameQ[i + 1]) + 256 * int'(frameQ[i + 2]);
    i       = i + 3;
    expOver = (expLen > 512);
    expOk   = 1'b0;
    if (!expOver) begin
      x = 8'h00;
      for (int k = 0; k < expLen; k++) begin
        x = x ^ frameQ[i + k];
        for (int b = 7; b >= 0; b--) expBits.push_back(frameQ[i + k][b]);
      end
      expOk = (frameQ[i + expLen] == x);
    end
  endtask

  // Present one byte starting at a falling edge; wait for acceptance
  task automatic applyStimulus(input logic [7:0] b);
    int budget;
    budget   = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) checkOutput("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic makeRandomFrame(input int garbage, input int len, input bit corrupt, input bit over);
    logic [7:0] g;
    logic [7:0] x;
    logic [15:0] l;
    frameQ.delete();
    for (int k = 0; k < garbage; k++) begin
      g = 8'($urandom_range(0, 255));
      if (g == 8'hA5) g = 8'h11;
      frameQ.push_back(g);
    end
    l = over ? 16'(513 + $urandom_range(0, 1000)) : 16'(len);
    frameQ.push_back(8'hA5);
    frameQ.push_back(l[7:0]);
    frameQ.push_back(l[15:8]);
    if (!over) begin
      x = 8'h00;
      for (int k = 0; k < len; k++) begin
        g = 8'($urandom_range(0, 255));
        x = x ^ g;
        frameQ.push_back(g);
      end
      if (corrupt) x = x ^ (8'h01 << $urandom_range(0, 7));
      frameQ.push_back(x);
    end
  endtask

  // Send the whole frame, then check outcome against the model
  task automatic runFrame(input string tag);
    int bad;
    int n;
    logic latchAfterChk;
    modelFromFrame();
    shiftBits.delete();
    latchCount    = 0;
    notReadyCount = 0;
    foreach (frameQ[k]) applyStimulus(frameQ[k]);
    latchAfterChk = chain_latch;
    repeat (4) @(negedge clk);

    checkOutput({tag, "_latch_timing"}, 32'(latchAfterChk), 32'(expOk));
    checkOutput({tag, "_latch_count"}, 32'(latchCount), expOk ? 32'd1 : 32'd0);
    checkOutput({tag, "_state"}, 32'(state_o), expOk ? 32'd6 : 32'd7);
    checkOutput({tag, "_fabric_en"}, 32'(fabric_en), 32'(expOk));
    checkOutput({tag, "_error"}, 32'(error), 32'(!expOk));
    checkOutput({tag, "_shift_cycles"}, 32'(shiftBits.size()), expOver ? 32'd0 : 32'(8 * expLen));
    checkOutput({tag, "_stall_cycles"}, 32'(notReadyCount), expOver ? 32'd0 : 32'(8 * expLen));
    bad = 0;
    n = (shiftBits.size() < expBits.size()) ? shiftBits.size() : expBits.size();
    for (int k = 0; k < n; k++) if (shiftBits[k] != expBits[k]) bad++;
    checkOutput({tag, "_chain_bits"}, 32'(bad), 32'd0);
  endtask

  task automatic pulseReset();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_state", 32'(state_o), 32'd0);
    checkOutput("rst_outputs", {26'd0, chain_dout, chain_shift, chain_latch, fabric_en, error, busy}, 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] packed16;
    bit corrupt;
    bit over;

    $display("[TB] start");
    // Reset state
    #12;
    checkOutput("reset_state", 32'(state_o), 32'd0);
    checkOutput("reset_outputs", {26'd0, chain_dout, chain_shift, chain_latch, fabric_en, error, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic two-byte frame
    frameQ = '{8'hA5, 8'h02, 8'h00, 8'h3C, 8'hC3, 8'hFF};
    runFrame("basic");
    packed16 = 16'h0000;
    for (int k = 0; k < 16 && k < shiftBits.size(); k++) packed16[15 - k] = shiftBits[k];
    checkOutput("basic_pattern", 32'(packed16), 32'h3CC3);

    // Bad checksum, then recovery
    frameQ = '{8'hA5, 8'h02, 8'h00, 8'h3C, 8'hC3, 8'h00};
    runFrame("badchk");
    frameQ = '{8'hA5, 8'h01, 8'h00, 8'h81, 8'h81};
    runFrame("recover");

    // Over-length (513) rejected after header
    frameQ = '{8'hA5, 8'h01, 8'h02};
    runFrame("overlen");

    // Exactly MAX_BYTES is accepted and moves to LOAD
    applyStimulus(8'hA5);
    applyStimulus(8'h00);
    applyStimulus(8'h02);
    checkOutput("maxlen_state", 32'(state_o), 32'd3);
    checkOutput("maxlen_busy", 32'(busy), 32'd1);
    pulseReset();

    // Zero-length payload
    frameQ = '{8'hA5, 8'h00, 8'h00, 8'h00};
    runFrame("zerolen");

    // Garbage in IDLE ahead of a valid frame
    frameQ = '{8'h11, 8'h22, 8'hA5, 8'h01, 8'h00, 8'h5A, 8'h5A};
    runFrame("garbage");

    // Mid-frame MAGIC bytes used as payload
    frameQ = '{8'hA5, 8'h02, 8'h00, 8'hA5, 8'hA5, 8'h00};
    runFrame("magic_data");

    // Randomized frames
    for (int r = 0; r < 12; r++) begin
      corrupt = ($urandom_range(0, 3) == 0);
      over    = ($urandom_range(0, 7) == 0);
      makeRandomFrame($urandom_range(0, 2), $urandom_range(0, 6), corrupt, over);
      runFrame($sformatf("rand%0d", r));
    end

    // Reset during the shift of byte 2 of a 4-byte frame
    latchCount = 0;
    applyStimulus(8'hA5);
    applyStimulus(8'h04);
    applyStimulus(8'h00);
    applyStimulus(8'h12);
    repeat (8) @(negedge clk);
    applyStimulus(8'h34);
    repeat (3) @(negedge clk);
    checkOutput("midrst_in_shift", 32'(chain_shift), 32'd1);
    pulseReset();
    repeat (20) @(negedge clk);
    checkOutput("midrst_no_latch", 32'(latchCount), 32'd0);
    checkOutput("midrst_idle", 32'(state_o), 32'd0);
    makeRandomFrame(0, 4, 1'b0, 1'b0);
    runFrame("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fpga_cfg_loader.md
Name: fpga_cfg_loader

Overview:
Byte-stream configuration controller for the FPGA fabric tile. It receives a framed bitstream over an 8-bit valid/ready input fed from the dedicated input pins. It serialises the payload MSB-first into the fabric configuration shift chain, verifies an XOR checksum, and then commits the configuration with a latch pulse. The fabric datapath is enabled only after a verified load; a failed frame leaves the fabric disabled and flags an error.

Parameters:
MAGIC, 8'hA5, frame start byte
MAX_BYTES, 16'd512, largest accepted payload length in bytes

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
in_data  input  8  frame byte
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts byte this cycle
chain_dout  output  1  serial bit into config chain
chain_shift  output  1  chain shift enable; chain samples chain_dout on this cycle's rising edge
chain_latch  output  1  one-cycle commit pulse to chain shadow registers
fabric_en  output  1  fabric datapath enable
busy  output  1  frame in progress (states LEN_LO through CHECK)
error  output  1  last frame failed
state_o  output  3  current state encoding, debug

Behaviour:
- Transfer: a byte moves on a rising edge when in_valid && in_ready. in_ready is a combinational function of state only, never of in_valid.
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE; all counters, shift register and checksum = 0.
  - chain_dout=0, chain_shift=0, chain_latch=0, fabric_en=0, error=0.
- Frame format: MAGIC, LEN[7:0], LEN[15:8], LEN payload bytes, CHK, where CHK = XOR of all payload bytes (0x00 when LEN=0).
- State encodings: IDLE=0, LEN_LO=1, LEN_HI=2, LOAD=3, SHIFT=4, CHECK=5, DONE=6, ERROR=7.
- IDLE / DONE / ERROR (in_ready=1):
  - Accepted byte == MAGIC: go to LEN_LO, clear checksum, fabric_en<=0, error<=0.
  - Any other byte: consumed and dropped. State, fabric_en and error unchanged.
- LEN_LO (in_ready=1): latch low length byte, go to LEN_HI.
- LEN_HI (in_ready=1): latch high length byte.
  - LEN > MAX_BYTES: go to ERROR, error<=1.
  - LEN == 0: go to CHECK.
  - Otherwise: go to LOAD.
- LOAD (in_ready=1): on accept, shreg<=byte, checksum^=byte, bit counter=0, go to SHIFT.
- SHIFT (in_ready=0): lasts exactly 8 cycles.
  - Each cycle: chain_shift=1, chain_dout=shreg[7]; shreg shifts left at the edge.
  - After the 8th cycle, remaining length decrements. Go to CHECK if it reaches 0, else LOAD.
  - chain_shift=0 in every other state.
- Throughput: minimum 9 cycles per payload byte (1 accept + 8 shift). A payload of N bytes produces exactly 8N chain_shift cycles.
- CHECK (in_ready=1): on accept, compare the byte to the checksum.
  - Equal: chain_latch=1 for the following cycle only, fabric_en<=1, go to DONE.
  - Not equal: error<=1, no latch, fabric_en stays 0, go to ERROR.
- chain_latch is registered and asserts in the cycle after the CHK accept edge.
- busy=1 in LEN_LO, LEN_HI, LOAD, SHIFT, CHECK; 0 otherwise.
- Mid-frame MAGIC byte: treated as ordinary data or length; no resync until the frame completes or errors.
- Length counter is 16 bits, compared unsigned against MAX_BYTES. LEN == MAX_BYTES is accepted.
- Reset mid-frame: immediate return to reset values, no chain_latch issued. Partial chain contents are don't-care because the shadow registers were never committed.
- in_valid low in any accepting state: hold state, no side effects.

Test Plan:
- Frame A5 02 00 3C C3 FF, in_valid held high → chain_dout over 16 shift cycles = 0011_1100_1100_0011; chain_latch high exactly once, one cycle after the FF accept; fabric_en=1; error=0; state_o=6.
- Same frame with CHK=00 → no chain_latch, error=1, fabric_en=0, state_o=7. Then a new valid frame A5 01 00 81 81 → error=0, fabric_en=1.
- Frame A5 01 02 (LEN=513 > 512) → ERROR after the third byte, zero chain_shift cycles. Frame A5 00 02 (LEN=512) → state goes to LOAD.
- Frame A5 00 00 00 → no shift cycles, chain_latch pulse, fabric_en=1.
- Garbage bytes 11 22 in IDLE then a valid frame → garbage dropped, in_ready=1 throughout, load succeeds. During SHIFT, in_ready=0 for exactly 8 cycles per byte.
- rst_n pulsed low during the SHIFT of byte 2 of a 4-byte frame → all outputs return to reset values asynchronously, chain_latch never asserts, the next full frame loads correctly.
